// File: rtl/i2c_angle_responder_if.sv
// Open-drain I2C bus bundle: scl from the master, sda as the resolved line level,
// and sda_oe as the target's pull-down request (line is low whenever any agent pulls).
interface i2c_angle_responder_if;
    logic scl;
    logic sda;
    logic sda_oe;

    modport master (output scl, output sda, input sda_oe);
    modport slave  (input scl, input sda, output sda_oe);
endinterface

// File: rtl/i2c_angle_responder.sv
// AS5600-style I2C target serving a 12-bit angle, oversampling SCL/SDA in the clock domain.
// Optional: define I2C_ANGLE_GLITCH_FILTER_EN for a 3-sample majority filter on SCL/SDA.
module i2c_angle_responder #(
    parameter logic [6:0] DEV_ADDR    = 7'h36,
    parameter int         SYNC_STAGES = 2
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic [11:0]                 raw_angle,
    input  logic                        magnet_ok,
    i2c_angle_responder_if.slave        bus,
    output logic                        addr_hit,
    output logic                        rd_done,
    output logic                        busy
);

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RACK_CHK, WAIT_STOP
    } state_t;

    function automatic logic [7:0] reg_rd(input logic [7:0] a, input logic [11:0] sh,
                                          input logic mok);
        logic [7:0] v;
        v = 8'h00;
        case (a)
            8'h0B:        v = {2'b00, mok, 5'b00000};
            8'h0C, 8'h0E: v = {4'h0, sh[11:8]};
            8'h0D, 8'h0F: v = sh[7:0];
            default:      v = 8'h00;
        endcase
        return v;
    endfunction

    logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
    logic scl_s, sda_s, scl_c, sda_c;
    logic scl_prev_q, sda_prev_q;

    // Idle bus is high, so synchronizers reset to 1 to avoid phantom edges after reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], bus.scl};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], bus.sda};
        end
    end

    assign scl_s = scl_sync_q[SYNC_STAGES-1];
    assign sda_s = sda_sync_q[SYNC_STAGES-1];

`ifdef I2C_ANGLE_GLITCH_FILTER_EN
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    logic [1:0] scl_hist_q, sda_hist_q;
    logic       scl_flt_q, sda_flt_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            scl_hist_q <= '1;
            sda_hist_q <= '1;
            scl_flt_q  <= 1'b1;
            sda_flt_q  <= 1'b1;
        end else begin
            scl_hist_q <= {scl_hist_q[0], scl_s};
            sda_hist_q <= {sda_hist_q[0], sda_s};
            scl_flt_q  <= maj3(scl_s, scl_hist_q[0], scl_hist_q[1]);
            sda_flt_q  <= maj3(sda_s, sda_hist_q[0], sda_hist_q[1]);
        end
    end

    assign scl_c = scl_flt_q;
    assign sda_c = sda_flt_q;
`else
    assign scl_c = scl_s;
    assign sda_c = sda_s;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_prev_q <= scl_c;
            sda_prev_q <= sda_c;
        end
    end

    logic scl_rise, scl_fall, start_det, stop_det;
    assign scl_rise  = scl_c & ~scl_prev_q;
    assign scl_fall  = ~scl_c & scl_prev_q;
    assign start_det = scl_c & scl_prev_q & sda_prev_q & ~sda_c;
    assign stop_det  = scl_c & scl_prev_q & ~sda_prev_q & sda_c;

    state_t      state_q;
    logic [2:0]  cnt_q;
    logic [7:0]  shift_q;
    logic [7:0]  ptr_q;
    logic [11:0] shadow_q;
    logic [6:0]  tx_q;
    logic        rw_q, ack_on_q, rd_xfer_q;
    logic        sda_oe_q, addr_hit_q, rd_done_q, busy_q;
    logic [7:0]  rd_byte;

    // shadow_q is already refreshed by the time the first read byte is loaded.
    assign rd_byte = reg_rd(ptr_q, shadow_q, magnet_ok);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            cnt_q      <= 3'd0;
            shift_q    <= 8'h00;
            ptr_q      <= 8'h00;
            shadow_q   <= 12'h000;
            tx_q       <= 7'h00;
            rw_q       <= 1'b0;
            ack_on_q   <= 1'b0;
            rd_xfer_q  <= 1'b0;
            sda_oe_q   <= 1'b0;
            addr_hit_q <= 1'b0;
            rd_done_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            addr_hit_q <= 1'b0;
            rd_done_q  <= 1'b0;
            if (start_det) begin
                state_q  <= ADDR;
                cnt_q    <= 3'd0;
                ack_on_q <= 1'b0;
                sda_oe_q <= 1'b0;
                busy_q   <= 1'b0;
            end else if (stop_det) begin
                state_q   <= IDLE;
                ack_on_q  <= 1'b0;
                sda_oe_q  <= 1'b0;
                busy_q    <= 1'b0;
                rd_done_q <= rd_xfer_q;
                rd_xfer_q <= 1'b0;
            end else begin
                case (state_q)
                    ADDR, PTR, WDATA: begin
                        if (scl_rise) begin
                            shift_q <= {shift_q[6:0], sda_c};
                            cnt_q   <= cnt_q + 3'd1;
                            if (cnt_q == 3'd7) begin
                                ack_on_q <= 1'b0;
                                if (state_q == ADDR) begin
                                    rw_q    <= sda_c;
                                    state_q <= (shift_q[6:0] == DEV_ADDR) ? ADDR_ACK : WAIT_STOP;
                                end else begin
                                    state_q <= (state_q == PTR) ? PTR_ACK : WDATA_ACK;
                                end
                            end
                        end
                    end
                    // First fall after the 8th bit asserts ACK, the next fall ends it.
                    ADDR_ACK: begin
                        if (scl_fall) begin
                            if (!ack_on_q) begin
                                ack_on_q   <= 1'b1;
                                sda_oe_q   <= 1'b1;
                                addr_hit_q <= 1'b1;
                                busy_q     <= 1'b1;
                                rd_xfer_q  <= rw_q;
                                if (rw_q) shadow_q <= raw_angle;
                            end else begin
                                ack_on_q <= 1'b0;
                                cnt_q    <= 3'd0;
                                if (rw_q) begin
                                    tx_q     <= rd_byte[6:0];
                                    sda_oe_q <= ~rd_byte[7];
                                    state_q  <= RDATA;
                                end else begin
                                    sda_oe_q <= 1'b0;
                                    state_q  <= PTR;
                                end
                            end
                        end
                    end
                    PTR_ACK, WDATA_ACK: begin
                        if (scl_fall) begin
                            if (!ack_on_q) begin
                                ack_on_q <= 1'b1;
                                sda_oe_q <= 1'b1;
                                if (state_q == PTR_ACK) ptr_q <= shift_q;
                            end else begin
                                ack_on_q <= 1'b0;
                                sda_oe_q <= 1'b0;
                                cnt_q    <= 3'd0;
                                if (state_q == WDATA_ACK) ptr_q <= ptr_q + 8'd1;
                                state_q  <= WDATA;
                            end
                        end
                    end
                    RDATA: begin
                        if (scl_rise) begin
                            cnt_q <= cnt_q + 3'd1;
                            if (cnt_q == 3'd7) begin
                                ptr_q    <= ptr_q + 8'd1;
                                ack_on_q <= 1'b0;
                                state_q  <= RACK_CHK;
                            end
                        end else if (scl_fall) begin
                            sda_oe_q <= ~tx_q[6];
                            tx_q     <= {tx_q[5:0], 1'b0};
                        end
                    end
                    // ack_on_q here records that the master ACKed and wants another byte.
                    RACK_CHK: begin
                        if (scl_fall) begin
                            if (ack_on_q) begin
                                ack_on_q <= 1'b0;
                                cnt_q    <= 3'd0;
                                tx_q     <= rd_byte[6:0];
                                sda_oe_q <= ~rd_byte[7];
                                state_q  <= RDATA;
                            end else begin
                                sda_oe_q <= 1'b0;
                            end
                        end else if (scl_rise) begin
                            if (!sda_c) ack_on_q <= 1'b1;
                            else        state_q  <= WAIT_STOP;
                        end
                    end
                    WAIT_STOP: sda_oe_q <= 1'b0;
                    default:   state_q  <= IDLE;
                endcase
            end
        end
    end

    assign bus.sda_oe = sda_oe_q;
    assign addr_hit   = addr_hit_q;
    assign rd_done    = rd_done_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_i2c_angle_responder.sv
// Directed bench: an I2C master model exercises the angle responder; read bytes are
// checked against a scoreboard queue filled when each transfer is issued.
module tb_i2c_angle_responder;

    localparam int T = 5;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [11:0] raw_angle;
    logic        magnet_ok;
    logic        addr_hit, rd_done, busy;
    logic        m_low;

    int n_vec = 0;
    int n_err = 0;
    int hit_cnt = 0, rdd_cnt = 0, oe_cnt = 0;
    logic [7:0] exp_q[$];

    i2c_angle_responder_if bus ();

    assign bus.sda = ~(bus.sda_oe | m_low);

    i2c_angle_responder #(.DEV_ADDR(7'h36), .SYNC_STAGES(2)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .raw_angle (raw_angle),
        .magnet_ok (magnet_ok),
        .bus       (bus),
        .addr_hit  (addr_hit),
        .rd_done   (rd_done),
        .busy      (busy)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (addr_hit)   hit_cnt++;
        if (rd_done)    rdd_cnt++;
        if (bus.sda_oe) oe_cnt++;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic wr_bit(input logic b);
        m_low = ~b;
        cyc(T); bus.scl = 1'b1;
        cyc(2*T); bus.scl = 1'b0;
        cyc(T);
    endtask

    task automatic rd_bit(output logic v);
        m_low = 1'b0;
        cyc(T); bus.scl = 1'b1;
        cyc(T); v = bus.sda;
        cyc(T); bus.scl = 1'b0;
        cyc(T);
    endtask

    task automatic i2c_start();
        m_low = 1'b1;
        cyc(2*T); bus.scl = 1'b0;
        cyc(T);
    endtask

    task automatic i2c_rep_start();
        m_low = 1'b0;
        cyc(T); bus.scl = 1'b1;
        cyc(T); m_low = 1'b1;
        cyc(T); bus.scl = 1'b0;
        cyc(T);
    endtask

    task automatic i2c_stop();
        m_low = 1'b1;
        cyc(T); bus.scl = 1'b1;
        cyc(T); m_low = 1'b0;
        cyc(2*T);
    endtask

    task automatic wr_byte(input logic [7:0] b, output logic acked);
        logic v;
        for (int i = 7; i >= 0; i--) wr_bit(b[i]);
        rd_bit(v);
        acked = ~v;
    endtask

    task automatic rd_byte(input logic mack);
        logic [7:0] d;
        logic v;
        d = 8'h00;
        for (int i = 0; i < 8; i++) begin
            rd_bit(v);
            d = {d[6:0], v};
        end
        if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $error("FAIL scoreboard: observed %0h expected none queued", d);
        end else begin
            chk("rd_data", 32'(d), 32'(exp_q.pop_front()));
        end
        wr_bit(~mack);
        m_low = 1'b0;
    endtask

    function automatic logic [7:0] model_reg(input logic [7:0] a, input logic [11:0] ang,
                                             input logic mok);
        if (a == 8'h0B) return mok ? 8'h20 : 8'h00;
        if (a == 8'h0C || a == 8'h0E) return {4'h0, ang[11:8]};
        if (a == 8'h0D || a == 8'h0F) return ang[7:0];
        return 8'h00;
    endfunction

    task automatic set_ptr_then_read(input logic [7:0] p);
        logic ack;
        i2c_start();
        wr_byte(8'h6C, ack); chk("wr_addr_ack", 32'(ack), 32'd1);
        wr_byte(p, ack);     chk("ptr_ack", 32'(ack), 32'd1);
        i2c_rep_start();
        wr_byte(8'h6D, ack); chk("rd_addr_ack", 32'(ack), 32'd1);
    endtask

    initial begin
        logic ack, v;
        int h0, r0, o0;

        reset_n = 1'b0;
        bus.scl = 1'b1;
        m_low = 1'b0;
        raw_angle = 12'h000;
        magnet_ok = 1'b0;
        cyc(3);
        chk("rst_sda_oe", 32'(bus.sda_oe), 32'd0);
        chk("rst_addr_hit", 32'(addr_hit), 32'd0);
        chk("rst_rd_done", 32'(rd_done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        reset_n = 1'b1;
        cyc(5);

        // pointer 0x0C, repeated START, read hi/lo with NACK on the last byte
        raw_angle = 12'hA5C;
        h0 = hit_cnt; r0 = rdd_cnt;
        set_ptr_then_read(8'h0C);
        chk("busy_after_ack", 32'(busy), 32'd1);
        exp_q.push_back(8'h0A); exp_q.push_back(8'h5C);
        rd_byte(1'b1);
        rd_byte(1'b0);
        i2c_stop();
        chk("rd_done_pulse", 32'(rdd_cnt - r0), 32'd1);
        chk("addr_hit_pulses", 32'(hit_cnt - h0), 32'd2);
        chk("busy_after_stop", 32'(busy), 32'd0);

        // wrong address: no ACK, no drive, pointer left at 0x0E
        h0 = hit_cnt; o0 = oe_cnt;
        i2c_start();
        wr_byte(8'h6F, ack);
        chk("nomatch_ack", 32'(ack), 32'd0);
        i2c_stop();
        chk("nomatch_sda_drive", 32'(oe_cnt - o0), 32'd0);
        chk("nomatch_addr_hit", 32'(hit_cnt - h0), 32'd0);
        i2c_start();
        wr_byte(8'h6D, ack); chk("ptr_kept_ack", 32'(ack), 32'd1);
        exp_q.push_back(8'h0A);
        rd_byte(1'b0);
        i2c_stop();

        // shadow coherency across an angle change mid-burst
        raw_angle = 12'h0FF;
        set_ptr_then_read(8'h0C);
        exp_q.push_back(8'h00); exp_q.push_back(8'hFF);
        rd_byte(1'b1);
        raw_angle = 12'h100;
        rd_byte(1'b0);
        i2c_stop();

        // status register reports the magnet flag
        magnet_ok = 1'b1;
        set_ptr_then_read(8'h0B);
        exp_q.push_back(8'h20);
        rd_byte(1'b0);
        i2c_stop();

        // pointer wrap 0xFF -> 0x00 -> 0x01, then a long burst from 0x01
        set_ptr_then_read(8'hFF);
        exp_q.push_back(8'h00); exp_q.push_back(8'h00);
        rd_byte(1'b1);
        rd_byte(1'b0);
        i2c_stop();
        raw_angle = 12'h3C7;
        i2c_start();
        wr_byte(8'h6D, ack); chk("burst_addr_ack", 32'(ack), 32'd1);
        for (int i = 0; i < 13; i++) begin
            exp_q.push_back(model_reg(8'(i + 1), 12'h3C7, 1'b1));
            rd_byte(i != 12);
        end
        i2c_stop();

        // STOP injected during bit 4 of a read byte
        raw_angle = 12'h0FF;
        r0 = rdd_cnt;
        set_ptr_then_read(8'h0D);
        for (int i = 0; i < 3; i++) begin
            rd_bit(v);
            chk("pre_stop_bit", 32'(v), 32'd1);
        end
        i2c_stop();
        chk("stop_mid_sda_oe", 32'(bus.sda_oe), 32'd0);
        chk("stop_mid_busy", 32'(busy), 32'd0);
        chk("stop_mid_rd_done", 32'(rdd_cnt - r0), 32'd1);
        i2c_start();
        wr_byte(8'h6D, ack); chk("readdress_ack", 32'(ack), 32'd1);
        exp_q.push_back(8'hFF);
        rd_byte(1'b0);
        i2c_stop();

        // asynchronous reset while the address ACK is being driven
        i2c_start();
        for (int i = 7; i >= 0; i--) wr_bit(((8'h6C >> i) & 8'h01) != 0);
        chk("ack_driven", 32'(bus.sda_oe), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("rst_mid_sda_oe", 32'(bus.sda_oe), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_addr_hit", 32'(addr_hit), 32'd0);
        chk("rst_mid_rd_done", 32'(rd_done), 32'd0);
        cyc(2);
        m_low = 1'b0;
        bus.scl = 1'b1;
        cyc(3);
        reset_n = 1'b1;
        cyc(5);
        i2c_start();
        wr_byte(8'h6D, ack); chk("post_rst_ack", 32'(ack), 32'd1);
        exp_q.push_back(8'h00);
        rd_byte(1'b0);
        i2c_stop();
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
